// File: rtl/btn_pkg.sv
// Shared types and board-clock defaults for pushbutton conditioning.
// Button FSM state encoding and 100 MHz timing constants.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        HELD = 2'd2
    } btn_state_e;

    localparam int unsigned DB_CYCLES_10MS = 1_000_000;
    localparam int unsigned LONG_CYCLES_1S = 100_000_000;

endpackage

// File: rtl/btn_sync.sv
// Asynchronous pad synchroniser: STAGES-deep flop chain, async active-high clear.
// Latency STAGES edges; no flow control.
module btn_sync
    import btn_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton conditioner: synchronise, debounce, then classify as click or long hold.
// Level and pulses change SYNC_STAGES+DB_CYCLES edges after a stable pad level; no flow control.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = DB_CYCLES_10MS,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_1S
) (
    input  logic CLK100MHZ,
    input  logic RST,
    input  logic i_btn,
    output logic o_state,
    output logic o_ondn,
    output logic o_onup,
    output logic o_long,
    output logic o_click
);

    localparam int unsigned DB_W   = $clog2(DB_CYCLES);
    localparam int unsigned LONG_W = $clog2(LONG_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic s_btn;

    btn_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (CLK100MHZ),
        .rst (RST),
        .d_i (i_btn),
        .q_o (s_btn)
    );

    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              state_q, state_d;
    btn_state_e        fsm_q, fsm_d;
    logic              ondn_q, ondn_d, onup_q, onup_d;
    logic              long_q, long_d, click_q, click_d;
    logic              differ, db_done, acc_press, acc_rel;

    // Any sample back at the accepted level restarts the stability count.
    assign differ    = s_btn ^ state_q;
    assign db_done   = differ && (db_cnt_q == DB_LAST);
    assign acc_press = db_done & ~state_q;
    assign acc_rel   = db_done & state_q;

    always_comb begin
        db_cnt_d = '0;
        state_d  = state_q;
        if (db_done) begin
            state_d = ~state_q;
        end else if (differ) begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        long_cnt_d = long_cnt_q;
        ondn_d     = 1'b0;
        onup_d     = 1'b0;
        long_d     = 1'b0;
        click_d    = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (acc_press) begin
                    fsm_d      = DOWN;
                    ondn_d     = 1'b1;
                    long_cnt_d = '0;
                end
            end
            DOWN: begin
                // A release on the expiry edge still counts as a click.
                if (acc_rel) begin
                    fsm_d   = IDLE;
                    onup_d  = 1'b1;
                    click_d = 1'b1;
                end else if (long_cnt_q == LONG_LAST) begin
                    fsm_d  = HELD;
                    long_d = 1'b1;
                end else begin
                    long_cnt_d = long_cnt_q + LONG_W'(1);
                end
            end
            HELD: begin
                if (acc_rel) begin
                    fsm_d  = IDLE;
                    onup_d = 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            db_cnt_q   <= '0;
            long_cnt_q <= '0;
            state_q    <= 1'b0;
            fsm_q      <= IDLE;
            ondn_q     <= 1'b0;
            onup_q     <= 1'b0;
            long_q     <= 1'b0;
            click_q    <= 1'b0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            long_cnt_q <= long_cnt_d;
            state_q    <= state_d;
            fsm_q      <= fsm_d;
            ondn_q     <= ondn_d;
            onup_q     <= onup_d;
            long_q     <= long_d;
            click_q    <= click_d;
        end
    end

    assign o_state = state_q;
    assign o_ondn  = ondn_q;
    assign o_onup  = onup_q;
    assign o_long  = long_q;
    assign o_click = click_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected pulse events are queued with their
// cycle stamp and a negedge monitor pops and compares each pulse the DUT emits.
module tb_button_conditioner;

    localparam int LAT = 7;

    logic CLK100MHZ = 1'b0;
    logic RST       = 1'b1;
    logic i_btn     = 1'b0;
    logic o_state, o_ondn, o_onup, o_long, o_click;

    button_conditioner #(
        .SYNC_STAGES (2),
        .DB_CYCLES   (5),
        .LONG_CYCLES (20)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .RST       (RST),
        .i_btn     (i_btn),
        .o_state   (o_state),
        .o_ondn    (o_ondn),
        .o_onup    (o_onup),
        .o_long    (o_long),
        .o_click   (o_click)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int t;

    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    // pulses packed as {ondn, onup, long, click}
    typedef struct {
        int         cyc;
        logic [3:0] pulses;
        logic       st;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [3:0] mon_p;

    task automatic expect_ev(input int c, input logic [3:0] p, input logic s);
        exp_t e;
        e.cyc    = c;
        e.pulses = p;
        e.st     = s;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic hold(input logic v, input int n);
        i_btn = v;
        repeat (n) @(negedge CLK100MHZ);
    endtask

    always @(negedge CLK100MHZ) begin
        mon_p = {o_ondn, o_onup, o_long, o_click};
        if (mon_p != 4'b0000) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: cyc %0d pulses %b, required no pulse", cyc, mon_p);
            end else begin
                mon_e = sb.pop_front();
                if (cyc != mon_e.cyc || mon_p != mon_e.pulses || o_state != mon_e.st) begin
                    n_bad++;
                    $display("FAIL pulse_event: cyc %0d pulses %b state %b, required cyc %0d pulses %b state %b",
                             cyc, mon_p, o_state, mon_e.cyc, mon_e.pulses, mon_e.st);
                end
            end
        end
    end

    initial begin
        #1;
        check("rst_state", int'(o_state), 0);
        check("rst_pulses", int'({o_ondn, o_onup, o_long, o_click}), 0);
        repeat (3) @(negedge CLK100MHZ);
        RST = 1'b0;
        repeat (5) @(negedge CLK100MHZ);

        // clean press, then short click released 12 cycles after o_ondn
        t = cyc;
        expect_ev(t + LAT, 4'b1000, 1'b1);
        hold(1'b1, LAT + 12);
        t = cyc;
        expect_ev(t + LAT, 4'b0101, 1'b0);
        hold(1'b0, 20);

        // glitches of 4 high samples never reach the 5-sample threshold
        for (int i = 0; i < 3; i++) begin
            hold(1'b1, 4);
            hold(1'b0, 6);
        end
        check("glitch_state", int'(o_state), 0);

        // long press, then bouncy release
        t = cyc;
        expect_ev(t + LAT, 4'b1000, 1'b1);
        expect_ev(t + LAT + 20, 4'b0010, 1'b1);
        hold(1'b1, 30);
        hold(1'b0, 3);
        hold(1'b1, 3);
        hold(1'b0, 3);
        hold(1'b1, 3);
        check("bounce_state_held", int'(o_state), 1);
        t = cyc;
        expect_ev(t + LAT, 4'b0100, 1'b0);
        hold(1'b0, 20);

        // release accepted on the very edge the long count expires
        t = cyc;
        expect_ev(t + LAT, 4'b1000, 1'b1);
        expect_ev(t + LAT + 20, 4'b0101, 1'b0);
        hold(1'b1, LAT + 13);
        hold(1'b0, 20);

        // reset while held
        t = cyc;
        expect_ev(t + LAT, 4'b1000, 1'b1);
        expect_ev(t + LAT + 20, 4'b0010, 1'b1);
        hold(1'b1, 32);
        RST = 1'b1;
        #1;
        check("midrst_state", int'(o_state), 0);
        check("midrst_ondn", int'(o_ondn), 0);
        check("midrst_onup", int'(o_onup), 0);
        check("midrst_long", int'(o_long), 0);
        check("midrst_click", int'(o_click), 0);
        repeat (2) @(negedge CLK100MHZ);
        RST = 1'b0;
        t = cyc;
        expect_ev(t + LAT, 4'b1000, 1'b1);
        expect_ev(t + LAT + 20, 4'b0010, 1'b1);
        hold(1'b1, 30);
        t = cyc;
        expect_ev(t + LAT, 4'b0100, 1'b0);
        hold(1'b0, 20);

        check("scoreboard_drained", sb.size(), 0);
        check("final_state", int'(o_state), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
